// File: rtl/wb8_pkg.sv
// Shared types and constants for the wb8 bus decoder.
package wb8_pkg;

  typedef enum logic [1:0] {StIdle, StActive, StError, StDone} wb8_state_e;

  typedef enum logic {CauseUnmapped = 1'b0, CauseTimeout = 1'b1} wb8_cause_e;

  localparam logic [7:0] ErrDataDefault = 8'hFF;

  // Slot index width, never below one bit so single-slave builds stay legal.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb8_addr_match.sv
// Combinational priority address matcher: lowest-index matching slot wins.
module wb8_addr_match
  import wb8_pkg::*;
#(
  parameter int unsigned             NSLAVES = 4,
  parameter logic [NSLAVES*32-1:0]   BASES   = '0,
  parameter logic [NSLAVES*32-1:0]   MASKS   = '0,
  localparam int unsigned            SelW    = sel_width(NSLAVES)
) (
  input  logic [31:0]     adr,
  output logic [SelW-1:0] sel,
  output logic            hit
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = int'(NSLAVES) - 1; i >= 0; i--) begin
      if ((adr & MASKS[32*i +: 32]) == BASES[32*i +: 32]) begin
        sel = SelW'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb8_bus_decoder.sv
// Wishbone 8-bit address decoder / response mux with bus-timeout watchdog and fault capture.
module wb8_bus_decoder
  import wb8_pkg::*;
#(
  parameter int unsigned           NSLAVES       = 4,
  parameter logic [NSLAVES*32-1:0] BASES         = '0,
  parameter logic [NSLAVES*32-1:0] MASKS         = '0,
  parameter int                    DEFAULT_SLAVE = int'(NSLAVES) - 1,
  parameter int unsigned           TIMEOUT       = 255,
  parameter logic [7:0]            ERR_DATA      = ErrDataDefault
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [31:0]            ADR_I,
  input  logic                   STB_I,
  input  logic                   CYC_I,
  output logic [7:0]             DAT_O,
  output logic                   ACK_O,
  output logic                   ERR_O,
  output logic [NSLAVES-1:0]     S_STB_O,
  input  logic [8*NSLAVES-1:0]   S_DAT_I,
  input  logic [NSLAVES-1:0]     S_ACK_I,
  input  logic                   I_fault_clr,
  output logic                   O_fault_valid,
  output logic                   O_fault_cause,
  output logic [31:0]            O_fault_adr,
  output logic [7:0]             O_fault_cnt
);

  localparam int unsigned       SelW       = sel_width(NSLAVES);
  localparam int unsigned       TimerW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TimerW-1:0] TimerMax   = TimerW'(TIMEOUT);
  localparam bit                HasDefault = (DEFAULT_SLAVE >= 0);

  wb8_state_e        state_q, state_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [31:0]       adr_q, adr_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              fault_valid_q, fault_valid_d;
  wb8_cause_e        fault_cause_q, fault_cause_d;
  logic [31:0]       fault_adr_q, fault_adr_d;
  logic [7:0]        fault_cnt_q, fault_cnt_d;

  logic [SelW-1:0] m_sel;
  logic            m_hit;
  logic            req;
  logic            ack_sel;
  logic            expired;
  logic            err_entry;
  wb8_cause_e      err_cause;
  logic [31:0]     err_adr;

  wb8_addr_match #(
    .NSLAVES (NSLAVES),
    .BASES   (BASES),
    .MASKS   (MASKS)
  ) u_addr_match (
    .adr (ADR_I),
    .sel (m_sel),
    .hit (m_hit)
  );

  assign req     = STB_I & CYC_I;
  assign ack_sel = S_ACK_I[sel_q];
  assign expired = (TIMEOUT != 0) && (timer_q == TimerMax);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    timer_d   = '0;
    S_STB_O   = '0;
    ACK_O     = 1'b0;
    ERR_O     = 1'b0;
    DAT_O     = '0;
    err_entry = 1'b0;
    err_cause = CauseUnmapped;
    err_adr   = ADR_I;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          adr_d = ADR_I;
          if (m_hit || HasDefault) begin
            sel_d   = m_hit ? m_sel : SelW'(DEFAULT_SLAVE);
            state_d = StActive;
          end else begin
            state_d   = StError;
            err_entry = 1'b1;
          end
        end
      end
      StActive: begin
        // A master abort wins over everything, including a same-cycle slave ack.
        if (!req) begin
          state_d = StIdle;
        end else begin
          DAT_O = S_DAT_I[8*sel_q +: 8];
          if (ack_sel) begin
            S_STB_O[sel_q] = 1'b1;
            ACK_O          = 1'b1;
            state_d        = StDone;
          end else if (expired) begin
            state_d   = StError;
            err_entry = 1'b1;
            err_cause = CauseTimeout;
            err_adr   = adr_q;
          end else begin
            S_STB_O[sel_q] = 1'b1;
            timer_d        = timer_q + 1'b1;
          end
        end
      end
      StError: begin
        ACK_O   = 1'b1;
        ERR_O   = 1'b1;
        DAT_O   = ERR_DATA;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // First fault is kept until cleared; a clear coincident with a new fault re-arms capture.
  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_cause_d = fault_cause_q;
    fault_adr_d   = fault_adr_q;
    fault_cnt_d   = fault_cnt_q;
    if (err_entry) begin
      if (fault_cnt_q != 8'hFF) begin
        fault_cnt_d = fault_cnt_q + 8'd1;
      end
      if (!fault_valid_q || I_fault_clr) begin
        fault_valid_d = 1'b1;
        fault_cause_d = err_cause;
        fault_adr_d   = err_adr;
      end
    end else if (I_fault_clr) begin
      fault_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      adr_q         <= '0;
      timer_q       <= '0;
      fault_valid_q <= 1'b0;
      fault_cause_q <= CauseUnmapped;
      fault_adr_q   <= '0;
      fault_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      adr_q         <= adr_d;
      timer_q       <= timer_d;
      fault_valid_q <= fault_valid_d;
      fault_cause_q <= fault_cause_d;
      fault_adr_q   <= fault_adr_d;
      fault_cnt_q   <= fault_cnt_d;
    end
  end

  assign O_fault_valid = fault_valid_q;
  assign O_fault_cause = fault_cause_q;
  assign O_fault_adr   = fault_adr_q;
  assign O_fault_cnt   = fault_cnt_q;

endmodule

// File: tb/tb_wb8_bus_decoder.sv
// Directed self-checking bench for wb8_bus_decoder (4 slots, no default slave, TIMEOUT=8).
module tb_wb8_bus_decoder;

  localparam logic [127:0] Bases = {32'h00002000, 32'h00001000, 32'hFFFFF800, 32'hFFFFF000};
  localparam logic [127:0] Masks = {32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF800, 32'hFFFFF000};

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic        stb;
  logic        cyc;
  logic [7:0]  dat_o;
  logic        ack_o;
  logic        err_o;
  logic [3:0]  s_stb;
  logic [31:0] s_dat;
  logic [3:0]  s_ack;
  logic        fault_clr;
  logic        fault_valid;
  logic        fault_cause;
  logic [31:0] fault_adr;
  logic [7:0]  fault_cnt;

  int n_checks = 0;
  int n_errors = 0;

  wb8_bus_decoder #(
    .NSLAVES       (4),
    .BASES         (Bases),
    .MASKS         (Masks),
    .DEFAULT_SLAVE (-1),
    .TIMEOUT       (8),
    .ERR_DATA      (8'hFF)
  ) dut (
    .CLK_I         (clk),
    .RST_I         (rst_n),
    .ADR_I         (adr),
    .STB_I         (stb),
    .CYC_I         (cyc),
    .DAT_O         (dat_o),
    .ACK_O         (ack_o),
    .ERR_O         (err_o),
    .S_STB_O       (s_stb),
    .S_DAT_I       (s_dat),
    .S_ACK_I       (s_ack),
    .I_fault_clr   (fault_clr),
    .O_fault_valid (fault_valid),
    .O_fault_cause (fault_cause),
    .O_fault_adr   (fault_adr),
    .O_fault_cnt   (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drop_all();
    adr       = '0;
    stb       = 1'b0;
    cyc       = 1'b0;
    s_ack     = '0;
    s_dat     = '0;
    fault_clr = 1'b0;
  endtask

  task automatic start(input logic [31:0] a);
    adr = a;
    stb = 1'b1;
    cyc = 1'b1;
  endtask

  // From the ACK cycle: one DONE cycle, then back in IDLE with inputs quiet.
  task automatic finish_xfer();
    @(posedge clk); #1;
    drop_all();
    @(posedge clk); #1;
  endtask

  task automatic run_timeout(input string tag, input logic [31:0] a, input logic [3:0] exp_stb);
    int  n;
    bit  seen;
    start(a);
    @(posedge clk); #1;
    @(negedge clk);
    check_val({tag, "_stb_rise"}, 32'(s_stb), 32'(exp_stb));
    n    = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge clk); #1;
      n++;
      @(negedge clk);
      if (n == 8) check_val({tag, "_stb_drop"}, 32'(s_stb), 32'h0);
      if (ack_o) seen = 1'b1;
    end
    check_val({tag, "_latency"}, 32'(n), 32'd9);
    check_val({tag, "_err"}, 32'(err_o), 32'h1);
    check_val({tag, "_dat"}, 32'(dat_o), 32'hFF);
  endtask

  initial begin
    drop_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_stb", 32'(s_stb), 32'h0);
    check_val("rst_ack", 32'(ack_o), 32'h0);
    check_val("rst_err", 32'(err_o), 32'h0);
    check_val("rst_fvalid", 32'(fault_valid), 32'h0);
    check_val("rst_fadr", fault_adr, 32'h0);
    check_val("rst_fcnt", 32'(fault_cnt), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Mapped read, slave acks in its second strobed cycle.
    start(32'hFFFFF004);
    @(negedge clk);
    check_val("rd_no_early_stb", 32'(s_stb), 32'h0);
    @(posedge clk); #1;
    s_ack = 4'b0010;
    @(negedge clk);
    check_val("rd_stb", 32'(s_stb), 32'h1);
    check_val("rd_foreign_ack", 32'(ack_o), 32'h0);
    @(posedge clk); #1;
    s_ack = 4'b0001;
    s_dat = 32'h0000005A;
    @(negedge clk);
    check_val("rd_ack", 32'(ack_o), 32'h1);
    check_val("rd_dat", 32'(dat_o), 32'h5A);
    check_val("rd_err", 32'(err_o), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rd_gap_stb", 32'(s_stb), 32'h0);
    check_val("rd_gap_ack", 32'(ack_o), 32'h0);
    @(posedge clk); #1;
    drop_all();

    // Slots 0 and 1 overlap at 0xFFFFF900; slot 0 must win.
    start(32'hFFFFF900);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("ovl_stb", 32'(s_stb), 32'h1);
    @(posedge clk); #1;
    s_ack = 4'b0001;
    s_dat = 32'h00000033;
    @(negedge clk);
    check_val("ovl_dat", 32'(dat_o), 32'h33);
    finish_xfer();

    // Unmapped access.
    start(32'h12345678);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("um_ack", 32'(ack_o), 32'h1);
    check_val("um_err", 32'(err_o), 32'h1);
    check_val("um_dat", 32'(dat_o), 32'hFF);
    check_val("um_stb", 32'(s_stb), 32'h0);
    check_val("um_fvalid", 32'(fault_valid), 32'h1);
    check_val("um_fcause", 32'(fault_cause), 32'h0);
    check_val("um_fadr", fault_adr, 32'h12345678);
    check_val("um_fcnt", 32'(fault_cnt), 32'h1);
    finish_xfer();

    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    @(negedge clk);
    check_val("clr_fvalid", 32'(fault_valid), 32'h0);
    check_val("clr_fcnt", 32'(fault_cnt), 32'h1);

    // Timeouts: first one captured, second only counted.
    run_timeout("to1", 32'h00001010, 4'b0100);
    check_val("to1_fcause", 32'(fault_cause), 32'h1);
    check_val("to1_fadr", fault_adr, 32'h00001010);
    check_val("to1_fcnt", 32'(fault_cnt), 32'h2);
    finish_xfer();
    run_timeout("to2", 32'h00002020, 4'b1000);
    check_val("to2_fadr", fault_adr, 32'h00001010);
    check_val("to2_fcnt", 32'(fault_cnt), 32'h3);
    finish_xfer();

    // Slave ack in the expiry cycle completes normally.
    start(32'h00001010);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("ackexp_rise", 32'(s_stb), 32'h4);
    repeat (8) @(posedge clk);
    #1;
    s_ack = 4'b0100;
    s_dat = 32'h00A50000;
    @(negedge clk);
    check_val("ackexp_ack", 32'(ack_o), 32'h1);
    check_val("ackexp_err", 32'(err_o), 32'h0);
    check_val("ackexp_dat", 32'(dat_o), 32'hA5);
    finish_xfer();
    check_val("ackexp_fcnt", 32'(fault_cnt), 32'h3);

    // Master abort.
    start(32'h00001010);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("abort_rise", 32'(s_stb), 32'h4);
    @(posedge clk); #1;
    stb = 1'b0;
    @(negedge clk);
    check_val("abort_stb", 32'(s_stb), 32'h0);
    check_val("abort_ack", 32'(ack_o), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("abort_idle_stb", 32'(s_stb), 32'h0);
    check_val("abort_idle_ack", 32'(ack_o), 32'h0);
    check_val("abort_fcnt", 32'(fault_cnt), 32'h3);
    drop_all();
    @(posedge clk); #1;

    // Asynchronous reset mid-transfer.
    start(32'h00001010);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("mrst_rise", 32'(s_stb), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mrst_stb", 32'(s_stb), 32'h0);
    check_val("mrst_ack", 32'(ack_o), 32'h0);
    check_val("mrst_fcnt", 32'(fault_cnt), 32'h0);
    check_val("mrst_fvalid", 32'(fault_valid), 32'h0);
    drop_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clear coincident with a new unmapped fault.
    start(32'h12345678);
    @(posedge clk); #1;
    finish_xfer();
    check_val("cc_pre_fvalid", 32'(fault_valid), 32'h1);
    start(32'h0BADF00D);
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    @(negedge clk);
    check_val("cc_err", 32'(err_o), 32'h1);
    check_val("cc_fvalid", 32'(fault_valid), 32'h1);
    check_val("cc_fadr", fault_adr, 32'h0BADF00D);
    check_val("cc_fcnt", 32'(fault_cnt), 32'h2);
    finish_xfer();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
